// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Purpose  : Machine-mode trap sequencer. Arbitrates synchronous exceptions,
//            a level-sensitive external interrupt (edge-captured into a
//            pending flag) and MRET. A trap writes mepc/mcause in one cycle
//            (SAVE) and redirects the core in the following cycle (JUMP).
//            MRET goes straight to JUMP and redirects to mepc.
// Ports    : clk, reset        - clock / synchronous active-high reset
//            excValid/Code/Pc  - exception report from the core
//            irqReq, irqEn     - interrupt line and global enable (MIE)
//            curPc             - resume PC saved when an interrupt is taken
//            mretReq           - MRET executed
//            mtvecDo, mepcDo   - CSR read values
//            mepcWe/Di         - mepc write strobe / data
//            mcauseWe/Di       - mcause write strobe / data
//            stall             - core must hold (busy sequencing)
//            redirect/Pc       - core must load redirectPc this cycle
// Options  : TRAP_CTRL_VECTORED_EN - vectored interrupt targets when
//            mtvecDo[1:0] == 1 (base + 4*cause). Default: base address only.
// Revision : 1.0 - initial release
// ============================================================================
module trap_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        excValid,
  input  logic [3:0]  excCode,
  input  logic [31:0] excPc,
  input  logic        irqReq,
  input  logic        irqEn,
  input  logic [31:0] curPc,
  input  logic        mretReq,
  input  logic [31:0] mtvecDo,
  input  logic [31:0] mepcDo,
  output logic        mepcWe,
  output logic [31:0] mepcDi,
  output logic        mcauseWe,
  output logic [31:0] mcauseDi,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirectPc
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SAVE = 2'd1;
  localparam logic [1:0] S_JUMP = 2'd2;

  localparam logic [31:0] IRQ_CAUSE = 32'h8000_000B;

  logic [1:0]  state;
  logic        irqPrev;
  logic        irqPending;
  logic [31:0] causeQ;
  logic [31:0] epcQ;
  logic        mretQ;      // current JUMP was entered from MRET, not a trap

  logic        idle;
  logic        irqEdge;
  logic        takeExc;
  logic        takeIrq;
  logic        takeMret;
  logic [31:0] trapBase;
  logic [31:0] trapTarget;

  assign idle     = (state == S_IDLE);
  assign irqEdge  = irqReq & ~irqPrev;
  assign takeExc  = idle & excValid;
  assign takeIrq  = idle & ~excValid & irqPending & irqEn;
  assign takeMret = idle & ~excValid & ~(irqPending & irqEn) & mretReq;

  assign trapBase = {mtvecDo[31:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
  // Only interrupts vector; exceptions (cause[31]=0) always use the base.
  always_comb begin
    trapTarget = trapBase;
    if (causeQ[31] && (mtvecDo[1:0] == 2'b01))
      trapTarget = trapBase + {26'd0, causeQ[3:0], 2'b00};
  end
`else
  assign trapTarget = trapBase;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      irqPrev    <= 1'b0;
      irqPending <= 1'b0;
      causeQ     <= 32'd0;
      epcQ       <= 32'd0;
      mretQ      <= 1'b0;
      mepcWe     <= 1'b0;
      mcauseWe   <= 1'b0;
      redirect   <= 1'b0;
    end else begin
      irqPrev <= irqReq;
      // Taking the interrupt wins over a coincident edge: that edge is lost.
      if (takeIrq)
        irqPending <= 1'b0;
      else if (irqEdge)
        irqPending <= 1'b1;

      mepcWe   <= 1'b0;
      mcauseWe <= 1'b0;
      redirect <= 1'b0;

      case (state)
        S_IDLE: begin
          if (takeExc) begin
            causeQ   <= {28'd0, excCode};
            epcQ     <= excPc;
            mretQ    <= 1'b0;
            mepcWe   <= 1'b1;
            mcauseWe <= 1'b1;
            state    <= S_SAVE;
          end else if (takeIrq) begin
            causeQ   <= IRQ_CAUSE;
            epcQ     <= curPc;
            mretQ    <= 1'b0;
            mepcWe   <= 1'b1;
            mcauseWe <= 1'b1;
            state    <= S_SAVE;
          end else if (takeMret) begin
            mretQ    <= 1'b1;
            redirect <= 1'b1;
            state    <= S_JUMP;
          end
        end
        S_SAVE: begin
          redirect <= 1'b1;
          state    <= S_JUMP;
        end
        S_JUMP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Data buses are qualified by their strobes so they read 0 when idle.
  assign mepcDi     = mepcWe   ? {epcQ[31:2], 2'b00} : 32'd0;
  assign mcauseDi   = mcauseWe ? causeQ : 32'd0;
  // mepcDo is taken live during JUMP so a late CSR update is honoured.
  assign redirectPc = redirect ? (mretQ ? mepcDo : trapTarget) : 32'd0;
  assign stall      = ~idle;

endmodule
`default_nettype wire
